count_sequencer: RTL

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_sequencer.sv | 91 +++++++++
 1 files changed

// File: rtl/count_sequencer.sv
// count_sequencer: FSM that steers an external load/enable counter from a captured start value to a captured end value.
// Optional build macro AUTO_RELOAD_EN: after DONE, reload the captured range and run again until abort.
module count_sequencer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_out,
    output logic             load,
    output logic             enab,
    output logic [WIDTH-1:0] cnt_in,
    output logic             busy,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] start_reg;
    logic [WIDTH-1:0] end_reg;
    logic             at_end;

    assign at_end = cnt_out == end_reg;
    assign cnt_in = start_reg;

    // count only while running, not held or aborted, and short of the terminal value
    always_comb enab = (state == RUN) && !pause && !abort && !at_end;

    // state sequencing with registered load/busy/done decoded from the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            start_reg <= '0;
            end_reg   <= '0;
            load      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    start_reg <= start_val;
                    end_reg   <= end_val;
                    state     <= LOAD;
                    load      <= 1'b1;
                    busy      <= 1'b1;
                end
                LOAD: begin
                    load  <= 1'b0;
                    state <= abort ? IDLE : RUN;
                    busy  <= !abort;
                end
                RUN: if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (at_end) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else if (pause) begin
                    state <= PAUSE;
                end
                PAUSE: if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (!pause) begin
                    state <= RUN;
                end
                DONE: begin
                    done <= 1'b0;
`ifdef AUTO_RELOAD_EN
                    state <= abort ? IDLE : LOAD;
                    load  <= !abort;
                    busy  <= !abort;
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: begin
                    state <= IDLE;
                    load  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
